// File: rtl/codec_config_seq.sv
// WM8731 power-up register sequencer over a valid/ready I2C command port.
// Optional macro CODEC_CFG_VOLUME_EN adds a headphone volume update port.
module codec_config_seq #(
  parameter logic [6:0] DEV_ADDR     = 7'h1A,
  parameter int         PWRUP_CYCLES = 1000,
  parameter int         MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
`ifdef CODEC_CFG_VOLUME_EN
  input  logic        vol_valid,
  input  logic [6:0]  vol_level,
  output logic        vol_ready,
`endif
  output logic        cmd_valid,
  output logic [23:0] cmd_data,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  step
);

  typedef enum logic [2:0] {
    PWRUP, ISSUE, WAIT, DONE, ERROR
  } state_t;

  localparam logic [15:0] PWRUP_LOAD = 16'(PWRUP_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);
  localparam logic [3:0]  LAST       = 4'd10;
  localparam logic [3:0]  VOL_L      = 4'hE;
  localparam logic [3:0]  VOL_R      = 4'hF;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  retry, retry_n;
  logic [3:0]  step_n;
  logic        cmd_valid_n;
  logic [23:0] cmd_data_n;
  logic        busy_n, done_n, error_n;
  logic [6:0]  lvl_n;
  logic        vol_go;

  function automatic logic [15:0] word_of(
    input logic [3:0] idx,
    input logic [6:0] v
  );
    logic [15:0] w;
    unique case (idx)
      4'd0:    w = 16'h1E00;
      4'd1:    w = 16'h0C10;
      4'd2:    w = 16'h0017;
      4'd3:    w = 16'h0217;
      4'd4:    w = 16'h0479;
      4'd5:    w = 16'h0679;
      4'd6:    w = 16'h0812;
      4'd7:    w = 16'h0A00;
      4'd8:    w = 16'h0E02;
      4'd9:    w = 16'h1001;
      4'd10:   w = 16'h1201;
      VOL_L:   w = {7'h02, 2'b10, v};
      VOL_R:   w = {7'h03, 2'b00, v};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

`ifdef CODEC_CFG_VOLUME_EN
  logic [6:0] lvl;

  assign vol_go = (state == DONE) && vol_valid
                  && vol_ready && !start;
  assign lvl_n  = vol_go ? vol_level : lvl;

  // Volume level latch and DONE-only ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl       <= '0;
      vol_ready <= 1'b0;
    end else begin
      lvl       <= lvl_n;
      vol_ready <= (state_n == DONE);
    end
  end
`else
  assign vol_go = 1'b0;
  assign lvl_n  = 7'd0;
`endif

  // Next state and next registered output values
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    retry_n    = retry;
    step_n     = step;
    cmd_data_n = cmd_data;
    unique case (state)
      PWRUP: begin
        if (cnt == 16'd0) begin
          state_n = ISSUE;
          step_n  = 4'd0;
          retry_n = 4'd0;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      ISSUE: begin
        if (cmd_valid && cmd_ready) state_n = WAIT;
      end
      WAIT: begin
        if (rsp_valid) begin
          if (!rsp_nack) begin
            retry_n = 4'd0;
            if (step == LAST || step == VOL_R) begin
              state_n = DONE;
            end else begin
              state_n = ISSUE;
              step_n  = step + 4'd1;
            end
          end else if (retry < RETRY_MAX) begin
            retry_n = retry + 4'd1;
            state_n = ISSUE;
          end else begin
            state_n = ERROR;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_n = ISSUE;
          step_n  = 4'd0;
          retry_n = 4'd0;
        end else if (vol_go) begin
          state_n = ISSUE;
          step_n  = VOL_L;
          retry_n = 4'd0;
        end
      end
      ERROR: begin
        if (start) begin
          state_n = ISSUE;
          step_n  = 4'd0;
          retry_n = 4'd0;
        end
      end
      default: state_n = PWRUP;
    endcase
    // Command word is loaded only on entry to ISSUE so it holds while valid
    if (state_n == ISSUE && state != ISSUE)
      cmd_data_n = {DEV_ADDR, 1'b0, word_of(step_n, lvl_n)};
    cmd_valid_n = (state_n == ISSUE);
    done_n      = (state_n == DONE);
    error_n     = (state_n == ERROR);
    busy_n      = !(done_n || error_n);
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PWRUP;
      cnt       <= PWRUP_LOAD;
      retry     <= '0;
      step      <= '0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      step      <= step_n;
      cmd_valid <= cmd_valid_n;
      cmd_data  <= cmd_data_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
    end
  end

endmodule

// File: tb/tb_codec_config_seq.sv
// Testbench for codec_config_seq: random I2C responder plus a
// table-level reference model of the expected command stream.
`timescale 1ns/1ps
module tb_codec_config_seq;

  localparam int PWR  = 8;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic        rsp_nack = 1'b0;
  logic        cmd_valid;
  logic [23:0] cmd_data;
  logic        busy, done, error;
  logic [3:0]  step;
`ifdef CODEC_CFG_VOLUME_EN
  logic        vol_valid = 1'b0;
  logic [6:0]  vol_level = 7'd0;
  logic        vol_ready;
`endif

  always #5 clk = ~clk;

  codec_config_seq #(
    .DEV_ADDR(7'h1A),
    .PWRUP_CYCLES(PWR),
    .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
`ifdef CODEC_CFG_VOLUME_EN
    .vol_valid(vol_valid),
    .vol_level(vol_level),
    .vol_ready(vol_ready),
`endif
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid),
    .rsp_nack(rsp_nack),
    .busy(busy),
    .done(done),
    .error(error),
    .step(step)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [23:0] log_q[$];
  logic [23:0] exp_q[$];
  int  nack_left [128];
  int  plan [11];
  int  ready_hold = 0;
  int  rsp_cnt = 0;
  bit  pend_nack = 1'b0;
  bit  exp_err;
  int  exp_step;

  function automatic logic [15:0] tbl(int i);
    case (i)
      0: return 16'h1E00;
      1: return 16'h0C10;
      2: return 16'h0017;
      3: return 16'h0217;
      4: return 16'h0479;
      5: return 16'h0679;
      6: return 16'h0812;
      7: return 16'h0A00;
      8: return 16'h0E02;
      9: return 16'h1001;
      10: return 16'h1201;
      default: return 16'h0000;
    endcase
  endfunction

  // I2C master model: random ready, logs accepted words, delayed response
  always @(negedge clk) begin
    logic [6:0] ra;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_nack  = pend_nack;
      end
    end
    if (ready_hold > 0 && cmd_valid) begin
      cmd_ready = 1'b0;
      ready_hold--;
    end else begin
      cmd_ready = ($urandom_range(0, 3) != 0);
    end
    if (reset_n && cmd_valid && cmd_ready) begin
      log_q.push_back(cmd_data);
      ra = cmd_data[15:9];
      pend_nack = (nack_left[ra] > 0);
      if (pend_nack) nack_left[ra]--;
      rsp_cnt = $urandom_range(1, 4);
    end
  end

  task automatic arm_plan();
    logic [15:0] w;
    foreach (nack_left[i]) nack_left[i] = 0;
    for (int i = 0; i < 11; i++) begin
      w = tbl(i);
      nack_left[w[15:9]] = plan[i];
    end
  endtask

  function automatic void model_run();
    int tries;
    exp_q.delete();
    exp_err  = 1'b0;
    exp_step = 10;
    for (int i = 0; i < 11; i++) begin
      tries = (plan[i] > MAXR) ? MAXR + 1 : plan[i] + 1;
      for (int k = 0; k < tries; k++)
        exp_q.push_back({8'h34, tbl(i)});
      if (plan[i] > MAXR) begin
        exp_err  = 1'b1;
        exp_step = i;
        break;
      end
    end
  endfunction

  function automatic bit log_matches();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (log_q[i])
      if (log_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int count_word(logic [23:0] w);
    int n = 0;
    foreach (log_q[i]) if (log_q[i] == w) n++;
    return n;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    int first = -1;
    foreach (plan[i]) plan[i] = 0;
    arm_plan();
    model_run();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cmd_valid got %b exp 0", cmd_valid);
    end
    n_checks++;
    if (cmd_data !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_cmd_data got %h exp 000000", cmd_data);
    end
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got b%b d%b e%b exp 1 0 0",
               busy, done, error);
    end
    n_checks++;
    if (step !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_step got %0d exp 0", step);
    end
    log_q.delete();
    reset_n = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (cmd_valid) begin
        first = c;
        break;
      end
    end
    n_checks++;
    if (first != PWR) begin
      n_fail++;
      $display("FAIL pwrup_latency got %0d exp %0d", first, PWR);
    end
    n_checks++;
    if (cmd_data !== 24'h341E00) begin
      n_fail++;
      $display("FAIL first_cmd got %h exp 341e00", cmd_data);
    end
  endtask

  task automatic test_nominal();
    bit ok;
    wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_timeout got busy %b exp 0", busy);
    end
    n_checks++;
    if (!log_matches()) begin
      n_fail++;
      $display("FAIL nominal_log got %0d cmds exp %0d",
               log_q.size(), exp_q.size());
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_flags got d%b b%b e%b exp 1 0 0",
               done, busy, error);
    end
    n_checks++;
    if (step !== 4'd10) begin
      n_fail++;
      $display("FAIL nominal_step got %0d exp 10", step);
    end
  endtask

  task automatic test_retry();
    bit ok;
    foreach (plan[i]) plan[i] = 0;
    plan[3] = 2;
    arm_plan();
    model_run();
    log_q.delete();
    do_start();
    n_checks++;
    if (done !== 1'b0 || cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_edge got d%b v%b exp 0 1",
               done, cmd_valid);
    end
    n_checks++;
    if (cmd_data !== 24'h341E00) begin
      n_fail++;
      $display("FAIL restart_cmd got %h exp 341e00", cmd_data);
    end
    wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1 || !log_matches()) begin
      n_fail++;
      $display("FAIL retry_log got %0d cmds exp %0d ok %b",
               log_q.size(), exp_q.size(), ok);
    end
    n_checks++;
    if (count_word(24'h340217) != 3) begin
      n_fail++;
      $display("FAIL retry_count got %0d exp 3",
               count_word(24'h340217));
    end
    n_checks++;
    if (error !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL retry_flags got e%b d%b exp 0 1", error, done);
    end
  endtask

  task automatic test_nack_error();
    bit ok;
    foreach (plan[i]) plan[i] = 0;
    plan[5] = 99;
    arm_plan();
    model_run();
    log_q.delete();
    do_start();
    wait_idle(ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (ok !== 1'b1 || !log_matches()) begin
      n_fail++;
      $display("FAIL err_log got %0d cmds exp %0d ok %b",
               log_q.size(), exp_q.size(), ok);
    end
    n_checks++;
    if (count_word(24'h340679) != MAXR + 1) begin
      n_fail++;
      $display("FAIL err_count got %0d exp %0d",
               count_word(24'h340679), MAXR + 1);
    end
    n_checks++;
    if (count_word(24'h340812) != 0) begin
      n_fail++;
      $display("FAIL err_next_entry got %0d exp 0",
               count_word(24'h340812));
    end
    n_checks++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_flags got e%b d%b b%b exp 1 0 0",
               error, done, busy);
    end
    n_checks++;
    if (step !== 4'd5 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_step got %0d v%b exp 5 0", step, cmd_valid);
    end
  endtask

  task automatic test_stall();
    bit ok;
    foreach (plan[i]) plan[i] = 0;
    arm_plan();
    model_run();
    log_q.delete();
    ready_hold = 20;
    do_start();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_data !== 24'h341E00) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d got v%b %h exp 1 341e00",
                 c, cmd_valid, cmd_data);
      end
    end
    wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1 || !log_matches() || done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_seq got %0d cmds d%b exp %0d 1",
               log_q.size(), done, exp_q.size());
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    bit hit = 1'b0;
    foreach (plan[i]) plan[i] = 0;
    arm_plan();
    model_run();
    log_q.delete();
    do_start();
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (step == 4'd4) begin
        hit = 1'b1;
        break;
      end
    end
    do_start();
    n_checks++;
    if (hit !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start got hit %b busy %b exp 1 1",
               hit, busy);
    end
    wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1 || !log_matches()) begin
      n_fail++;
      $display("FAIL busy_start_log got %0d cmds exp %0d",
               log_q.size(), exp_q.size());
    end
    log_q.delete();
    do_start();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || cmd_valid !== 1'b1
        || step !== 4'd0 || cmd_data !== 24'h341E00) begin
      n_fail++;
      $display("FAIL done_restart got d%b b%b v%b s%0d %h exp 0 1 1 0 341e00",
               done, busy, cmd_valid, step, cmd_data);
    end
    wait_idle(ok);
    n_checks++;
    if (ok !== 1'b1 || !log_matches()) begin
      n_fail++;
      $display("FAIL done_restart_log got %0d cmds exp %0d",
               log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 8; it++) begin
      foreach (plan[i])
        plan[i] = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 5);
      arm_plan();
      model_run();
      log_q.delete();
      do_start();
      wait_idle(ok);
      repeat (3) @(negedge clk);
      n_checks++;
      if (ok !== 1'b1 || !log_matches()) begin
        n_fail++;
        $display("FAIL rand_log it %0d got %0d cmds exp %0d",
                 it, log_q.size(), exp_q.size());
      end
      n_checks++;
      if (error !== exp_err || done !== !exp_err
          || step !== 4'(exp_step)) begin
        n_fail++;
        $display("FAIL rand_end it %0d got e%b d%b s%0d exp e%b s%0d",
                 it, error, done, step, exp_err, exp_step);
      end
    end
  endtask

`ifdef CODEC_CFG_VOLUME_EN
  task automatic vol_run(input logic [6:0] lv, input int nr);
    bit ok;
    bit seen = 1'b0;
    logic [23:0] wl, wr;
    wl = {8'h34, 7'h02, 2'b10, lv};
    wr = {8'h34, 7'h03, 2'b00, lv};
    foreach (nack_left[i]) nack_left[i] = 0;
    nack_left[3] = nr;
    exp_q.delete();
    exp_q.push_back(wl);
    for (int k = 0; k <= nr; k++) exp_q.push_back(wr);
    n_checks++;
    if (vol_ready !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL vol_ready_done got r%b d%b exp 1 1",
               vol_ready, done);
    end
    log_q.delete();
    @(negedge clk);
    vol_valid = 1'b1;
    vol_level = lv;
    @(negedge clk);
    vol_valid = 1'b0;
    n_checks++;
    if (vol_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0
        || step !== 4'hE || cmd_data !== wl) begin
      n_fail++;
      $display("FAIL vol_start got r%b b%b d%b s%h %h exp 0 1 0 e %h",
               vol_ready, busy, done, step, cmd_data, wl);
    end
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (vol_ready) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL vol_ready_busy got %b exp 0", seen);
    end
    n_checks++;
    if (ok !== 1'b1 || !log_matches()) begin
      n_fail++;
      $display("FAIL vol_log got %0d cmds exp %0d",
               log_q.size(), exp_q.size());
    end
    n_checks++;
    if (done !== 1'b1 || vol_ready !== 1'b1 || step !== 4'hF) begin
      n_fail++;
      $display("FAIL vol_end got d%b r%b s%h exp 1 1 f",
               done, vol_ready, step);
    end
  endtask

  task automatic test_volume();
    bit ok;
    foreach (plan[i]) plan[i] = 0;
    arm_plan();
    model_run();
    log_q.delete();
    do_start();
    wait_idle(ok);
    vol_run(7'h60, 0);
    vol_run(7'($urandom_range(0, 127)), 1);
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_retry();
    test_nack_error();
    test_stall();
    test_start_ignored();
    test_random();
`ifdef CODEC_CFG_VOLUME_EN
    test_volume();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
